// File: rtl/uart_aes_frame_ctrl_if.sv
// rtl/uart_aes_frame_ctrl_if.sv - UART byte stream in, AES key/block out, status flags
interface uart_aes_frame_ctrl_if;
  logic         Rx_DV_in;
  logic [7:0]   Rx_Byte_in;
  logic         Blk_Ready_in;
  logic         Clr_Err_in;
  logic [127:0] Key_out;
  logic         Key_Valid_out;
  logic [127:0] Blk_Data_out;
  logic         Blk_Valid_out;
  logic         Busy_out;
  logic         Err_Cmd_out;
  logic         Err_Timeout_out;
  logic         Overrun_out;

  modport slave (
    input  Rx_DV_in, Rx_Byte_in, Blk_Ready_in, Clr_Err_in,
    output Key_out, Key_Valid_out, Blk_Data_out, Blk_Valid_out,
           Busy_out, Err_Cmd_out, Err_Timeout_out, Overrun_out
  );

  modport master (
    output Rx_DV_in, Rx_Byte_in, Blk_Ready_in, Clr_Err_in,
    input  Key_out, Key_Valid_out, Blk_Data_out, Blk_Valid_out,
           Busy_out, Err_Cmd_out, Err_Timeout_out, Overrun_out
  );
endinterface

// File: rtl/uart_aes_frame_ctrl.sv
// rtl/uart_aes_frame_ctrl.sv - frames UART bytes into AES-128 key and plaintext blocks
module uart_aes_frame_ctrl #(
  parameter int          TIMEOUT_CLKS = 100000,
  parameter int          CNT_W        = 17,
  parameter logic [7:0]  CMD_KEY      = 8'hA5,
  parameter logic [7:0]  CMD_DATA     = 8'h5A
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  uart_aes_frame_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    RX_KEY      = 2'd1,
    RX_DATA     = 2'd2,
    WAIT_ACCEPT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [127:0]       shift_q, shift_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       blk_q, blk_d;
  logic               key_vld_q, key_vld_d;
  logic               blk_vld_q, blk_vld_d;
  logic               err_cmd_q, err_cmd_d;
  logic               err_tmo_q, err_tmo_d;
  logic               ovr_q, ovr_d;
  logic [127:0]       shift_in;

  assign shift_in = {shift_q[119:0], bus.Rx_Byte_in};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      shift_q   <= '0;
      key_q     <= '0;
      blk_q     <= '0;
      key_vld_q <= 1'b0;
      blk_vld_q <= 1'b0;
      err_cmd_q <= 1'b0;
      err_tmo_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      shift_q   <= shift_d;
      key_q     <= key_d;
      blk_q     <= blk_d;
      key_vld_q <= key_vld_d;
      blk_vld_q <= blk_vld_d;
      err_cmd_q <= err_cmd_d;
      err_tmo_q <= err_tmo_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    key_d     = key_q;
    blk_d     = blk_q;
    key_vld_d = key_vld_q;
    blk_vld_d = blk_vld_q;
    err_cmd_d = 1'b0;
    err_tmo_d = 1'b0;
    ovr_d     = ovr_q;

    // Clear first so that a drop in the same cycle overrides it.
    if (bus.Clr_Err_in) ovr_d = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (bus.Rx_DV_in) begin
          if (bus.Rx_Byte_in == CMD_KEY) begin
            state_d = RX_KEY;
            cnt_d   = '0;
          end else if (bus.Rx_Byte_in == CMD_DATA && key_vld_q) begin
            state_d = RX_DATA;
            cnt_d   = '0;
          end else begin
            err_cmd_d = 1'b1;
          end
        end
      end

      RX_KEY, RX_DATA: begin
        if (bus.Rx_DV_in) begin
          shift_d = shift_in;
          tmo_d   = '0;
          if (cnt_q == 4'd15) begin
            cnt_d = '0;
            if (state_q == RX_KEY) begin
              key_d     = shift_in;
              key_vld_d = 1'b1;
              state_d   = IDLE;
            end else begin
              blk_d     = shift_in;
              blk_vld_d = 1'b1;
              state_d   = WAIT_ACCEPT;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Abort leaves the committed key and block registers untouched.
          err_tmo_d = 1'b1;
          cnt_d     = '0;
          tmo_d     = '0;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end

      WAIT_ACCEPT: begin
        if (bus.Rx_DV_in) ovr_d = 1'b1;
        if (blk_vld_q && bus.Blk_Ready_in) begin
          blk_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.Key_out         = key_q;
  assign bus.Key_Valid_out   = key_vld_q;
  assign bus.Blk_Data_out    = blk_q;
  assign bus.Blk_Valid_out   = blk_vld_q;
  assign bus.Busy_out        = (state_q != IDLE);
  assign bus.Err_Cmd_out     = err_cmd_q;
  assign bus.Err_Timeout_out = err_tmo_q;
  assign bus.Overrun_out     = ovr_q;

endmodule

// File: tb/tb_uart_aes_frame_ctrl.sv
// tb/tb_uart_aes_frame_ctrl.sv - scoreboard bench for uart_aes_frame_ctrl
module tb_uart_aes_frame_ctrl;
  logic CLK;
  logic RST_N;

  uart_aes_frame_ctrl_if bus();

  uart_aes_frame_ctrl #(
    .TIMEOUT_CLKS (64),
    .CNT_W        (7),
    .CMD_KEY      (8'hA5),
    .CMD_DATA     (8'h5A)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_key_q[$];
  logic [127:0] exp_blk_q[$];
  logic [127:0] key_prev;
  int           err_cmd_cnt = 0;
  int           err_tmo_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_blk(input logic [7:0] base);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], 8'(base + 8'(i))};
    return v;
  endfunction

  // Scoreboard side: pop expected results as the DUT commits or hands over blocks.
  always @(negedge CLK) begin
    logic [127:0] e;
    if (!RST_N) begin
      key_prev = '0;
    end else begin
      if (bus.Err_Cmd_out) err_cmd_cnt++;
      if (bus.Err_Timeout_out) err_tmo_cnt++;
      if (bus.Key_out !== key_prev) begin
        if (exp_key_q.size() > 0) e = exp_key_q.pop_front();
        else e = ~bus.Key_out;
        check("key_commit", bus.Key_out, e);
        check("key_valid", 128'(bus.Key_Valid_out), 128'd1);
        key_prev = bus.Key_out;
      end
      if (bus.Blk_Valid_out && bus.Blk_Ready_in) begin
        if (exp_blk_q.size() > 0) e = exp_blk_q.pop_front();
        else e = ~bus.Blk_Data_out;
        check("blk_accept", bus.Blk_Data_out, e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.Rx_DV_in   = 1'b1;
    bus.Rx_Byte_in = b;
    @(posedge CLK);
    #1;
    bus.Rx_DV_in   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] base, input int n);
    send_byte(cmd);
    for (int i = 0; i < n; i++) send_byte(8'(base + 8'(i)));
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    idle(3);
    RST_N = 1'b1;
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           c0;
    logic         stable;
    logic [127:0] k;

    RST_N            = 1'b0;
    bus.Rx_DV_in     = 1'b0;
    bus.Rx_Byte_in   = 8'h00;
    bus.Blk_Ready_in = 1'b0;
    bus.Clr_Err_in   = 1'b0;
    idle(3);
    check("rst_key", bus.Key_out, 128'd0);
    check("rst_flags", 128'({bus.Key_Valid_out, bus.Blk_Valid_out, bus.Busy_out,
                             bus.Err_Cmd_out, bus.Err_Timeout_out, bus.Overrun_out}), 128'd0);
    check("rst_blk", bus.Blk_Data_out, 128'd0);
    RST_N = 1'b1;
    idle(1);

    // 1: key load then data frame with ready already high
    exp_key_q.push_back(mk_blk(8'h00));
    send_frame(8'hA5, 8'h00, 16);
    check("t1_key", bus.Key_out, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_keyvld", 128'(bus.Key_Valid_out), 128'd1);
    check("t1_busy_idle", 128'(bus.Busy_out), 128'd0);
    bus.Blk_Ready_in = 1'b1;
    exp_blk_q.push_back(mk_blk(8'h10));
    send_frame(8'h5A, 8'h10, 16);
    check("t1_blkvld", 128'(bus.Blk_Valid_out), 128'd1);
    check("t1_blk", bus.Blk_Data_out, 128'h101112131415161718191A1B1C1D1E1F);
    idle(1);
    check("t1_blkvld_drop", 128'(bus.Blk_Valid_out), 128'd0);
    check("t1_busy_after", 128'(bus.Busy_out), 128'd0);
    bus.Blk_Ready_in = 1'b0;

    // 2: data command before any key
    do_reset();
    send_byte(8'h5A);
    check("t2_errcmd", 128'(bus.Err_Cmd_out), 128'd1);
    check("t2_busy", 128'(bus.Busy_out), 128'd0);
    idle(1);
    check("t2_errcmd_pulse", 128'(bus.Err_Cmd_out), 128'd0);
    c0 = err_cmd_cnt;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(8'h10 + 8'(i)));
      check("t2_busy_loop", 128'(bus.Busy_out), 128'd0);
    end
    idle(1);
    check("t2_errcmd_count", 128'(err_cmd_cnt - c0), 128'd16);

    // 3: timeout abort keeps the old key; byte at expiry wins
    k = mk_blk(8'h20);
    exp_key_q.push_back(k);
    send_frame(8'hA5, 8'h20, 16);
    c0 = err_tmo_cnt;
    send_frame(8'hA5, 8'hE0, 5);
    idle(63);
    check("t3_no_tmo_yet", 128'(bus.Err_Timeout_out), 128'd0);
    check("t3_busy_wait", 128'(bus.Busy_out), 128'd1);
    idle(1);
    check("t3_tmo_pulse", 128'(bus.Err_Timeout_out), 128'd1);
    check("t3_idle", 128'(bus.Busy_out), 128'd0);
    check("t3_key_kept", bus.Key_out, k);
    idle(1);
    check("t3_tmo_once", 128'(bus.Err_Timeout_out), 128'd0);
    check("t3_tmo_count", 128'(err_tmo_cnt - c0), 128'd1);
    exp_key_q.push_back(mk_blk(8'h40));
    send_frame(8'hA5, 8'h40, 5);
    idle(63);
    send_byte(8'h45);
    check("t3v_busy", 128'(bus.Busy_out), 128'd1);
    for (int i = 6; i < 16; i++) send_byte(8'(8'h40 + 8'(i)));
    check("t3v_key", bus.Key_out, mk_blk(8'h40));
    check("t3v_no_tmo", 128'(err_tmo_cnt - c0), 128'd1);

    // 4: backpressure and overrun
    exp_blk_q.push_back(mk_blk(8'h60));
    send_frame(8'h5A, 8'h60, 16);
    send_byte(8'hA5);
    send_byte(8'h77);
    check("t4_ovr", 128'(bus.Overrun_out), 128'd1);
    check("t4_blk", bus.Blk_Data_out, mk_blk(8'h60));
    stable = 1'b1;
    repeat (10) begin
      idle(1);
      if (bus.Blk_Data_out !== mk_blk(8'h60) || !bus.Blk_Valid_out || !bus.Overrun_out) stable = 1'b0;
    end
    bus.Clr_Err_in = 1'b1;
    idle(1);
    bus.Clr_Err_in = 1'b0;
    check("t4_ovr_clr", 128'(bus.Overrun_out), 128'd0);
    bus.Clr_Err_in = 1'b1;
    send_byte(8'h11);
    bus.Clr_Err_in = 1'b0;
    check("t4_set_wins", 128'(bus.Overrun_out), 128'd1);
    repeat (38) begin
      idle(1);
      if (bus.Blk_Data_out !== mk_blk(8'h60) || !bus.Blk_Valid_out || !bus.Busy_out) stable = 1'b0;
    end
    check("t4_stable", 128'(stable), 128'd1);
    bus.Blk_Ready_in = 1'b1;
    idle(1);
    check("t4_accept", 128'(bus.Blk_Valid_out), 128'd0);
    check("t4_idle", 128'(bus.Busy_out), 128'd0);
    check("t4_ovr_sticky", 128'(bus.Overrun_out), 128'd1);
    bus.Blk_Ready_in = 1'b0;
    bus.Clr_Err_in   = 1'b1;
    idle(1);
    bus.Clr_Err_in   = 1'b0;

    // 5: unknown command
    send_byte(8'h3C);
    check("t5_errcmd", 128'(bus.Err_Cmd_out), 128'd1);
    check("t5_busy", 128'(bus.Busy_out), 128'd0);

    // 6: reset mid-frame, then a fresh key
    send_frame(8'hA5, 8'h80, 8);
    #2;
    RST_N = 1'b0;
    #1;
    check("t6_key_zero", bus.Key_out, 128'd0);
    check("t6_flags", 128'({bus.Key_Valid_out, bus.Blk_Valid_out, bus.Busy_out,
                            bus.Err_Cmd_out, bus.Err_Timeout_out, bus.Overrun_out}), 128'd0);
    check("t6_blk_zero", bus.Blk_Data_out, 128'd0);
    idle(3);
    RST_N = 1'b1;
    idle(1);
    exp_key_q.push_back(mk_blk(8'h90));
    send_frame(8'hA5, 8'h90, 16);
    check("t6_key", bus.Key_out, mk_blk(8'h90));
    idle(2);

    check("sb_key_drained", 128'(exp_key_q.size()), 128'd0);
    check("sb_blk_drained", 128'(exp_blk_q.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
